// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU-control decode, EX operand forwarding and ALUSrc select.
//   Inputs : clk, rst_n (async, active-low), stall, flush, id_* decoded fields,
//            fwd_a/fwd_b forward selects, exmem_result/memwb_result forwarded values.
//   Outputs: alu_ctrl/alu_a/alu_b to the ALU, ex_store_data, ex_write_reg, ex_rs/ex_rt,
//            ex_* control bits, ex_valid, bubble_cnt.
//   Macro  : ID_EX_BUBBLE_CNT_EN enables the saturating 16-bit bubble counter (else bubble_cnt = 0).
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          id_branch,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic [1:0]    fwd_a,
    input  logic [1:0]    fwd_b,
    input  logic [DW-1:0] exmem_result,
    input  logic [DW-1:0] memwb_result,
    output logic [3:0]    alu_ctrl,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_write_reg,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_branch,
    output logic          ex_valid,
    output logic [15:0]   bubble_cnt
);
    localparam logic [3:0] CTRL_ADD = 4'b0010;

    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, fwd_b_val;
    logic          ex_alu_src;
    logic [3:0]    ctrl_d;

    always_comb begin
        ctrl_d = 4'b1111;
        case (id_alu_op)
            2'b00: ctrl_d = 4'b0010;
            2'b01: ctrl_d = 4'b0110;
            2'b11: ctrl_d = 4'b0001;
            default:
                case (id_funct)
                    6'b100000: ctrl_d = 4'b0010;
                    6'b100010: ctrl_d = 4'b0110;
                    6'b100100: ctrl_d = 4'b0000;
                    6'b100101: ctrl_d = 4'b0001;
                    6'b101010: ctrl_d = 4'b0111;
                    default:   ctrl_d = 4'b1111;
                endcase
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            alu_ctrl      <= CTRL_ADD;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_write_reg  <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_src    <= 1'b0;
        end else if (flush) begin
            ex_valid      <= 1'b0;
            alu_ctrl      <= CTRL_ADD;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_write_reg  <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_src    <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            alu_ctrl      <= ctrl_d;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_write_reg  <= id_reg_dst ? id_rd : id_rt;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_branch     <= id_branch;
            ex_alu_src    <= id_alu_src;
        end
    end

    // Select 2'b11 falls back to the register value.
    assign alu_a = fwd_a == 2'b10 ? exmem_result :
                   fwd_a == 2'b01 ? memwb_result : ex_rs_data;
    assign fwd_b_val = fwd_b == 2'b10 ? exmem_result :
                       fwd_b == 2'b01 ? memwb_result : ex_rt_data;
    assign alu_b = ex_alu_src ? ex_imm : fwd_b_val;
    assign ex_store_data = fwd_b_val;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] cnt;
    // Counts edges whose next ex_valid is 0; a plain stall keeps the stage as-is and is not a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if ((flush || (!stall && !id_valid)) && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end
    assign bubble_cnt = cnt;
`else
    assign bubble_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed self-checking bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;
    logic        clk = 0, rst_n = 0, stall = 0, flush = 0, id_valid = 0;
    logic [1:0]  id_alu_op = 0, fwd_a = 0, fwd_b = 0;
    logic [5:0]  id_funct = 0;
    logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0, exmem_result = 0, memwb_result = 0;
    logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0;
    logic        id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_mem_to_reg = 0;
    logic        id_branch = 0, id_alu_src = 0, id_reg_dst = 0;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  ex_write_reg, ex_rs, ex_rt;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_valid;
    logic [15:0] bubble_cnt;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .fwd_a(fwd_a), .fwd_b(fwd_b), .exmem_result(exmem_result),
        .memwb_result(memwb_result), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_valid(ex_valid),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  rs, rt, wr;
        logic        rw, mr, mw, m2r, br, src;
    } st_t;

    st_t         m;
    int unsigned mcnt;
    int          checks = 0, failures = 0;
    logic [5:0]  functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        if (f == 6'b100000) return 4'b0010;
        if (f == 6'b100010) return 4'b0110;
        if (f == 6'b100100) return 4'b0000;
        if (f == 6'b100101) return 4'b0001;
        if (f == 6'b101010) return 4'b0111;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v);
        if (sel == 2'b10) return exmem_result;
        if (sel == 2'b01) return memwb_result;
        return reg_v;
    endfunction

    function automatic st_t bubble();
        st_t b = '0;
        b.ctrl = 4'b0010;
        return b;
    endfunction

    task automatic compare_all();
        logic [31:0] fb;
        fb = pick(fwd_b, m.rt_d);
        check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m.ctrl});
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
        check("alu_a", alu_a, pick(fwd_a, m.rs_d));
        check("alu_b", alu_b, m.src ? m.imm : fb);
        check("store_data", ex_store_data, fb);
        check("write_reg", {27'd0, ex_write_reg}, {27'd0, m.wr});
        check("ex_rs", {27'd0, ex_rs}, {27'd0, m.rs});
        check("ex_rt", {27'd0, ex_rt}, {27'd0, m.rt});
        check("ctl_bits", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch},
              {27'd0, m.rw, m.mr, m.mw, m.m2r, m.br});
`ifdef ID_EX_BUBBLE_CNT_EN
        check("bubble_cnt", {16'd0, bubble_cnt}, mcnt);
`else
        check("bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
`endif
    endtask

    // Update the model from the current inputs, advance one edge, then compare.
    task automatic step(input bit cmp);
        if (flush) m = bubble();
        else if (!stall) begin
            m.valid = id_valid; m.ctrl = ref_ctrl(id_alu_op, id_funct);
            m.rs_d = id_rs_data; m.rt_d = id_rt_data; m.imm = id_imm;
            m.rs = id_rs; m.rt = id_rt; m.wr = id_reg_dst ? id_rd : id_rt;
            m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
            m.m2r = id_mem_to_reg; m.br = id_branch; m.src = id_alu_src;
        end
        if ((flush || (!stall && !id_valid)) && mcnt != 32'hFFFF) mcnt++;
        @(posedge clk);
        #1;
        if (cmp) compare_all();
    endtask

    task automatic rand_id();
        id_valid = $urandom_range(0, 3) != 0;
        id_alu_op = 2'($urandom);
        id_funct = $urandom_range(0, 1) ? functs[$urandom_range(0, 4)] : 6'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src, id_reg_dst} = 7'($urandom);
    endtask

    task automatic load_dec(input logic [1:0] op, input logic [5:0] f, input logic [3:0] exp);
        id_valid = 1; id_alu_op = op; id_funct = f;
        step(1);
        check("decode", {28'd0, alu_ctrl}, {28'd0, exp});
    endtask

    initial begin
        m = bubble();
        mcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1;

        flush = 1; step(1); step(1); flush = 0;
        id_valid = 0; step(1);
        stall = 1; repeat (3) step(1); stall = 0;
`ifdef ID_EX_BUBBLE_CNT_EN
        check("bubble_seq", {16'd0, bubble_cnt}, 32'd3);
`else
        check("bubble_seq", {16'd0, bubble_cnt}, 32'd0);
`endif

        load_dec(2'b10, 6'b100100, 4'b0000);
        load_dec(2'b10, 6'b100101, 4'b0001);
        load_dec(2'b10, 6'b101010, 4'b0111);
        load_dec(2'b10, 6'b100010, 4'b0110);
        load_dec(2'b10, 6'b000000, 4'b1111);
        load_dec(2'b00, 6'b101010, 4'b0010);
        load_dec(2'b01, 6'b100100, 4'b0110);
        load_dec(2'b11, 6'b100000, 4'b0001);

        id_valid = 1; id_rs_data = 5; id_rt_data = 6; id_imm = 32'hFFFFFFFC; id_alu_src = 1;
        fwd_a = 0; fwd_b = 0;
        step(1);
        exmem_result = 9; memwb_result = 7;
        fwd_a = 2'b10; #1 check("fwd_a10", alu_a, 9);
        fwd_a = 2'b01; #1 check("fwd_a01", alu_a, 7);
        fwd_a = 2'b11; #1 check("fwd_a11", alu_a, 5);
        fwd_b = 2'b10; #1 check("alu_b_imm", alu_b, 32'hFFFFFFFC);
        check("store_fwd10", ex_store_data, 9);
        fwd_b = 2'b11; #1 check("store_fwd11", ex_store_data, 6);
        compare_all();

        id_valid = 1; id_alu_op = 0; id_rd = 3; id_reg_dst = 1; id_reg_write = 1;
        step(1);
        repeat (3) begin
            rand_id(); stall = 1; flush = 0;
            step(1);
            check("stall_wr", {27'd0, ex_write_reg}, 32'd3);
            check("stall_ctrl", {28'd0, alu_ctrl}, 32'd2);
        end
        stall = 0; id_rd = 9; id_reg_dst = 1; id_valid = 1;
        step(1);
        check("release_wr", {27'd0, ex_write_reg}, 32'd9);

        id_valid = 1; id_reg_write = 1; id_mem_write = 1; id_alu_op = 2'b01;
        step(1);
        flush = 1; stall = 1;
        step(1);
        check("fl_valid", {31'd0, ex_valid}, 0);
        check("fl_rw", {31'd0, ex_reg_write}, 0);
        check("fl_mw", {31'd0, ex_mem_write}, 0);
        check("fl_ctrl", {28'd0, alu_ctrl}, 32'd2);
        flush = 0; stall = 0;

        repeat (400) begin
            rand_id();
            stall = $urandom_range(0, 3) == 0;
            flush = $urandom_range(0, 7) == 0;
            fwd_a = 2'($urandom); fwd_b = 2'($urandom);
            exmem_result = $urandom; memwb_result = $urandom;
            step(1);
        end

        rand_id(); id_valid = 1; stall = 0; flush = 0;
        step(1);
        #2 rst_n = 0;
        m = bubble(); mcnt = 0;
        #1;
        check("rst_ctrl", {28'd0, alu_ctrl}, 32'd2);
        check("rst_valid", {31'd0, ex_valid}, 0);
        compare_all();
        #1 rst_n = 1;

`ifdef ID_EX_BUBBLE_CNT_EN
        flush = 1;
        repeat (65536) step(0);
        compare_all();
        check("sat", {16'd0, bubble_cnt}, 32'hFFFF);
        flush = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
